// File: rtl/tree_sum_accumulator_if.sv
// Stream, configuration and result handshake bundle for tree_sum_accumulator.
// master drives beats/config/ready; slave is the accumulator itself.
interface tree_sum_accumulator_if #(
    parameter int IN_WIDTH  = 35,
    parameter int OUT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
);
    logic                        i_valid;
    logic signed [IN_WIDTH-1:0]  i_sum;
    logic                        i_clear;
    logic [LEN_WIDTH-1:0]        cfg_len;
    logic [5:0]                  cfg_shift;
    logic signed [OUT_WIDTH-1:0] o_data;
    logic                        o_valid;
    logic                        o_sat;
    logic                        i_ready;
    logic                        o_busy;
    logic                        o_drop;

    modport master (
        output i_valid, i_sum, i_clear, cfg_len, cfg_shift, i_ready,
        input  o_data, o_valid, o_sat, o_busy, o_drop
    );

    modport slave (
        input  i_valid, i_sum, i_clear, cfg_len, cfg_shift, i_ready,
        output o_data, o_valid, o_sat, o_busy, o_drop
    );
endinterface

// File: rtl/tree_sum_accumulator.sv
// Accumulates groups of signed adder-tree sums, then shifts, saturates and presents one result.
// Optional macro TREE_ACC_ROUND_EN switches the final shift from floor to round-half-up.
module tree_sum_accumulator #(
    parameter int IN_WIDTH  = 35,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    tree_sum_accumulator_if.slave  bus
);
    localparam int ACC_EXT = ACC_WIDTH + 1;
    localparam int UPPER_W = ACC_EXT - OUT_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StAccum, StFlush} state_e;

    state_e                      state_q, state_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic [5:0]                  shift_q, shift_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic [LEN_WIDTH-1:0]        len_eff;
    logic [LEN_WIDTH-1:0]        cnt_inc;
    logic                        flush_fire;

    // One-cycle staging register between FLUSH and the output holding register
    logic signed [OUT_WIDTH-1:0] res_q, res_d;
    logic                        res_sat_q, res_sat_d;
    logic                        res_vld_q, res_vld_d;

    logic signed [OUT_WIDTH-1:0] data_q, data_d;
    logic                        sat_q, sat_d;
    logic                        valid_q, valid_d;
    logic                        drop_q, drop_d;

    logic signed [ACC_EXT-1:0]   acc_ext;
    logic signed [ACC_EXT-1:0]   shifted;
    logic [UPPER_W-1:0]          upper;
    logic                        clip;
    logic signed [OUT_WIDTH-1:0] sat_val;
`ifdef TREE_ACC_ROUND_EN
    logic signed [ACC_EXT-1:0]   rnd_add;
`endif

    always_comb begin
        sum_ext = ACC_WIDTH'(bus.i_sum);
        len_eff = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;
        cnt_inc = cnt_q + LEN_WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        if (bus.i_clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle, StFlush: begin
                    if (bus.i_valid) begin
                        // A beat during FLUSH opens the next group with no bubble
                        len_d   = len_eff;
                        shift_d = bus.cfg_shift;
                        acc_d   = sum_ext;
                        cnt_d   = LEN_WIDTH'(1);
                        state_d = (len_eff == LEN_WIDTH'(1)) ? StFlush : StAccum;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StAccum: begin
                    if (bus.i_valid) begin
                        acc_d = acc_q + sum_ext;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = StFlush;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        acc_ext = $signed({acc_q[ACC_WIDTH-1], acc_q});
`ifdef TREE_ACC_ROUND_EN
        rnd_add = '0;
        if (shift_q != 6'd0) begin
            rnd_add = ACC_EXT'(1) << (shift_q - 6'd1);
        end
        // Beyond ACC_WIDTH the rounded value is always in [0, 2^shift), so it shifts to zero
        if (int'(shift_q) > ACC_WIDTH) begin
            shifted = '0;
        end else begin
            shifted = (acc_ext + rnd_add) >>> shift_q;
        end
`else
        shifted = acc_ext >>> shift_q;
`endif
        upper = shifted[ACC_EXT-1:OUT_WIDTH-1];
        clip  = !((&upper) || (~|upper));
        if (clip) begin
            sat_val = shifted[ACC_EXT-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            sat_val = shifted[OUT_WIDTH-1:0];
        end
    end

    assign flush_fire = (state_q == StFlush) && !bus.i_clear;

    always_comb begin
        res_vld_d = flush_fire;
        res_d     = flush_fire ? sat_val : res_q;
        res_sat_d = flush_fire ? clip : res_sat_q;
    end

    always_comb begin
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
        if (res_vld_q) begin
            // A held, unaccepted result wins; the newcomer is lost and flagged
            if (valid_q && !bus.i_ready) begin
                drop_d = 1'b1;
            end else begin
                data_d  = res_q;
                sat_d   = res_sat_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
            res_vld_q <= 1'b0;
            data_q    <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
            res_vld_q <= res_vld_d;
            data_q    <= data_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_sat   = sat_q;
    assign bus.o_valid = valid_q;
    assign bus.o_drop  = drop_q;
    assign bus.o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed scoreboard bench for tree_sum_accumulator: expected results are queued at
// stimulus time and popped by a monitor on every accepted output transfer.
module tb_tree_sum_accumulator;
    localparam int IN_WIDTH  = 35;
    localparam int ACC_WIDTH = 48;
    localparam int OUT_WIDTH = 32;
    localparam int LEN_WIDTH = 16;

    typedef struct {
        logic signed [OUT_WIDTH-1:0] data;
        logic                        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    tree_sum_accumulator_if #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) bus ();

    tree_sum_accumulator #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input logic signed [IN_WIDTH-1:0] v);
        bus.i_valid = 1'b1;
        bus.i_sum   = v;
        tick();
        bus.i_valid = 1'b0;
        bus.i_sum   = '0;
    endtask

    task automatic push_exp(input logic signed [OUT_WIDTH-1:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int len, input int shift);
        bus.cfg_len   = LEN_WIDTH'(len);
        bus.cfg_shift = 6'(shift);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0d, expected no transfer", bus.o_data);
            end else begin
                mon_e = sb.pop_front();
                check("result_data", bus.o_data, mon_e.data);
                check("result_sat", bus.o_sat, mon_e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n         = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_sum     = '0;
        bus.i_clear   = 1'b0;
        bus.i_ready   = 1'b1;
        set_cfg(1, 0);
        ticks(2);
        rst_n = 1'b1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_sat", bus.o_sat, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_drop", bus.o_drop, 0);

        // Basic group, with a mid-group config change that must be ignored
        set_cfg(4, 0);
        push_exp(15, 1'b0);
        beat(10);
        set_cfg(2, 3);
        beat(-3);
        beat(7);
        beat(1);
        check("flush_busy", bus.o_busy, 1);
        check("lat_e0_valid", bus.o_valid, 0);
        tick();
        check("lat_e1_valid", bus.o_valid, 0);
        tick();
        check("lat_e2_valid", bus.o_valid, 1);
        check("lat_e2_data", bus.o_data, 15);
        tick();
        check("after_xfer_valid", bus.o_valid, 0);
        check("idle_busy", bus.o_busy, 0);

        // Positive saturation
        set_cfg(2, 0);
        push_exp(32'sh7FFF_FFFF, 1'b1);
        beat(35'sh3_FFFF_FFFF);
        beat(35'sh3_FFFF_FFFF);
        ticks(3);

        // Shift of a negative single beat
        set_cfg(1, 2);
`ifdef TREE_ACC_ROUND_EN
        push_exp(-1, 1'b0);
`else
        push_exp(-2, 1'b0);
`endif
        beat(-5);
        ticks(3);

        set_cfg(1, 1);
`ifdef TREE_ACC_ROUND_EN
        push_exp(-3, 1'b0);
`else
        push_exp(-4, 1'b0);
`endif
        beat(-7);
        ticks(3);

        set_cfg(1, 2);
`ifdef TREE_ACC_ROUND_EN
        push_exp(2, 1'b0);
`else
        push_exp(1, 1'b0);
`endif
        beat(6);
        ticks(3);

        // Length 0 behaves as 1
        set_cfg(0, 0);
        push_exp(9, 1'b0);
        beat(9);
        ticks(3);

        // Negative saturation
        set_cfg(1, 0);
        push_exp(32'sh8000_0000, 1'b1);
        beat(35'sh4_0000_0000);
        ticks(3);

        set_cfg(2, 4);
        push_exp(10, 1'b0);
        beat(100);
        beat(60);
        ticks(3);

        // Length-1 groups every cycle: results stream out with no gap
        set_cfg(1, 0);
        push_exp(1, 1'b0);
        push_exp(2, 1'b0);
        push_exp(3, 1'b0);
        beat(1);
        beat(2);
        beat(3);
        check("b2b_first_valid", bus.o_valid, 1);
        tick();
        check("b2b_no_gap_valid", bus.o_valid, 1);
        check("b2b_no_gap_data", bus.o_data, 2);
        ticks(3);
        check("b2b_no_drop", bus.o_drop, 0);

        // Back-to-back groups with i_ready low: second result is dropped
        bus.i_ready = 1'b0;
        set_cfg(2, 0);
        push_exp(11, 1'b0);
        beat(5);
        beat(6);
        beat(7);
        beat(8);
        ticks(3);
        check("drop_flag", bus.o_drop, 1);
        check("drop_hold_valid", bus.o_valid, 1);
        check("drop_hold_data", bus.o_data, 11);
        bus.i_ready = 1'b1;
        tick();
        check("drop_after_xfer_valid", bus.o_valid, 0);
        tick();
        check("drop_no_second", bus.o_valid, 0);
        check("drop_sticky", bus.o_drop, 1);

        // Clear with the second beat; the next three beats form a fresh group
        set_cfg(3, 0);
        push_exp(3, 1'b0);
        beat(7);
        bus.i_valid = 1'b1;
        bus.i_sum   = 9;
        bus.i_clear = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
        check("clear_busy_low", bus.o_busy, 0);
        beat(1);
        check("clear_busy_high", bus.o_busy, 1);
        beat(1);
        beat(1);
        ticks(3);
        check("clear_keeps_drop", bus.o_drop, 1);

        // Reset in the middle of a group
        set_cfg(4, 0);
        beat(5);
        beat(5);
        check("pre_rst_busy", bus.o_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", bus.o_valid, 0);
        check("mid_rst_data", bus.o_data, 0);
        check("mid_rst_sat", bus.o_sat, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_drop", bus.o_drop, 0);
        push_exp(20, 1'b0);
        for (int i = 0; i < 4; i++) beat(5);
        ticks(3);

        ticks(2);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
